fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin arbiter that shares a single FIFO write port between two requesters. Drives the select of the 2:1 write-data mux and the FIFO write enable, with burst fairness and FIFO-full backpressure. Sits between the two producer blocks and the FIFO; the data mux lives at the parent level and takes `mux_sel` from this block.

## Interface
- `BURST_MAX`, default 4: maximum consecutive writes granted to one requester while the other is waiting. Legal range ≥1.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `req0`, input, 1: requester 0 has a word to write; held until it is written.
- `req1`, input, 1: requester 1, same meaning as `req0`.
- `fifo_full`, input, 1: FIFO cannot accept a write this cycle.
- `gnt0`, output, 1: registered grant to requester 0.
- `gnt1`, output, 1: registered grant to requester 1.
- `mux_sel`, output, 1: data-mux select, equal to `gnt0`. 1 routes requester 0 (mux input `i0`); 0 routes requester 1 (`i1`).
- `fifo_wr_en`, output, 1: write strobe to the FIFO.

## Operation
- States: IDLE, G0, G1. `gnt0` = (state==G0); `gnt1` = (state==G1). At most one grant is high at a time.
- Write condition `wr` = ((G0 & req0) | (G1 & req1)) & ~fifo_full. `fifo_wr_en` = `wr` (combinational from registered state and inputs).
- `last` register records which requester was most recently granted. It updates on entry to G0 (0) or G1 (1).
- `burst_cnt` counts writes in the current grant. Width is clog2(BURST_MAX+1). It clears on any state change, increments on `wr`, and saturates at BURST_MAX.
- IDLE:
  - req0 & req1 → G0 if last==1, else G1.
  - Only req0 → G0. Only req1 → G1.
  - Otherwise stay in IDLE.
- G0:
  - If ~req0 → G1 if req1, else IDLE.
  - Else if req1 & (burst_cnt==BURST_MAX | (wr & burst_cnt==BURST_MAX-1)) → G1.
  - Else stay in G0.
- G1: mirror of G0 with the indices swapped.
- `fifo_full`:
  - Blocks the write and holds `burst_cnt`.
  - Does not block state transitions. A requester dropping its request, or a saturated burst with the other requester waiting, still switches the grant.
- Requester protocol: a word is consumed in any cycle where its grant, its request and ~fifo_full are all high. The requester may deassert `req` in the following cycle.

## Timing
- Reset values: state=IDLE, `gnt0`=0, `gnt1`=0, `mux_sel`=0, `fifo_wr_en`=0, `last`=1, `burst_cnt`=0.
- Reset is asynchronous. Asserting `rst_n` low mid-burst drops all grants and `fifo_wr_en` immediately, with no partial write.
- Latency: request to grant is 1 cycle. The first write happens in the cycle the grant rises, if the FIFO is not full.
- Sustained throughput: one write per cycle while any request is active and the FIFO is not full.
- Switch-over between requesters costs no idle cycle: the last write of G0 and the first write of G1 occur in consecutive cycles.
- Both requests asserted continuously, FIFO never full: the write pattern repeats as BURST_MAX writes from one requester, then BURST_MAX from the other.
- A lone requester is never preempted; `burst_cnt` sits at BURST_MAX.

## Structure
- Shared package `fifo_pkg` holds:
  - the state encoding localparams: IDLE=2'b00, G0=2'b01, G1=2'b10;
  - the default BURST_MAX.
- Sub-module `arb_burst_cnt`: saturating counter with `clr`, `inc` and an `at_limit` / `at_limit_m1` decode, parameterised by BURST_MAX.
- The 2-bit 2:1 data mux is instantiated by the parent, not inside this block.

## Test plan
- Reset, then req0=1 only → `gnt0`=1 and `mux_sel`=1 after 1 cycle; `fifo_wr_en`=1 every cycle thereafter; no preemption after 10 writes.
- req0=req1=1 from reset, BURST_MAX=4 → writes ordered 0,0,0,0,1,1,1,1,0… with no gap cycles.
- Requester 0 holds for 2 words, then drops while req1=1 → grant moves to G1 on the next cycle; 1's first write follows immediately.
- `fifo_full`=1 for 3 cycles mid-burst → `fifo_wr_en`=0 and `burst_cnt` held; the burst resumes with the remaining count when full clears.
- Both requesting with `fifo_full` stuck at 1 and a burst already saturated → grant still alternates; zero writes occur.
- `rst_n` pulsed low during G1 → all outputs return to 0 asynchronously; after release, a simultaneous request grants requester 0 first (`last`=1).

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } arb_state_e;

    localparam int BURST_MAX_DEF = 4;

    function automatic int cnt_w(input int bm);
        return $clog2(bm + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO handshake bundle seen by the arbiter (master) and its environment (slave).
interface fifo_wr_arbiter_if;

    logic req0;
    logic req1;
    logic fifo_full;
    logic gnt0;
    logic gnt1;
    logic mux_sel;
    logic fifo_wr_en;

    modport master (
        input  req0, req1, fifo_full,
        output gnt0, gnt1, mux_sel, fifo_wr_en
    );

    modport slave (
        output req0, req1, fifo_full,
        input  gnt0, gnt1, mux_sel, fifo_wr_en
    );

endinterface

// File: rtl/arb_burst_cnt.sv
// Saturating per-grant write counter with limit and limit-minus-one decodes.
module arb_burst_cnt
    import fifo_pkg::*;
#(
    parameter int BURST_MAX = BURST_MAX_DEF,
    parameter int CW        = cnt_w(BURST_MAX)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_at_limit,
    output logic o_at_limit_m1
);

    localparam logic [CW-1:0] LIM    = CW'(BURST_MAX);
    localparam logic [CW-1:0] LIM_M1 = CW'(BURST_MAX - 1);

    logic [CW-1:0] r_cnt;

    assign o_at_limit    = (r_cnt == LIM);
    assign o_at_limit_m1 = (r_cnt == LIM_M1);

    // Clear wins over increment: a write in the switching cycle belongs to the old grant.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc && !o_at_limit)
            r_cnt <= r_cnt + CW'(1);
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-fair arbiter sharing one FIFO write port between two requesters.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    fifo_wr_arbiter_if.master arb_if
);

    arb_state_e r_state;
    arb_state_e w_nxt;
    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_last;
    logic       w_wr;
    logic       w_at_lim;
    logic       w_at_lim_m1;
    logic       w_burst_done;

    assign w_wr = ((r_gnt0 & arb_if.req0) | (r_gnt1 & arb_if.req1)) & ~arb_if.fifo_full;
    // Burst ends either already saturated or on the write that reaches the limit.
    assign w_burst_done = w_at_lim | (w_wr & w_at_lim_m1);

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (arb_if.req0 && arb_if.req1) w_nxt = r_last ? G0 : G1;
                else if (arb_if.req0)           w_nxt = G0;
                else if (arb_if.req1)           w_nxt = G1;
            end
            G0: begin
                if (!arb_if.req0)                      w_nxt = arb_if.req1 ? G1 : IDLE;
                else if (arb_if.req1 && w_burst_done) w_nxt = G1;
            end
            G1: begin
                if (!arb_if.req1)                      w_nxt = arb_if.req0 ? G0 : IDLE;
                else if (arb_if.req0 && w_burst_done) w_nxt = G0;
            end
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_nxt;
            r_gnt0  <= (w_nxt == G0);
            r_gnt1  <= (w_nxt == G1);
            if (w_nxt == G0)      r_last <= 1'b0;
            else if (w_nxt == G1) r_last <= 1'b1;
        end
    end

    arb_burst_cnt #(
        .BURST_MAX(BURST_MAX)
    ) u_cnt (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clr        (w_nxt != r_state),
        .i_inc        (w_wr),
        .o_at_limit   (w_at_lim),
        .o_at_limit_m1(w_at_lim_m1)
    );

    assign arb_if.gnt0       = r_gnt0;
    assign arb_if.gnt1       = r_gnt1;
    assign arb_if.mux_sel    = r_gnt0;
    assign arb_if.fifo_wr_en = w_wr;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scenario bench for fifo_wr_arbiter against a grant-owner reference model.
module tb_fifo_wr_arbiter;

    localparam int BM = 4;

    logic        clk;
    logic        rst_n;
    int unsigned total;
    int unsigned bad;

    // Model: owner -1 = nobody, 0/1 = requester; writes counted in the current grant.
    int m_own;
    int m_last;
    int m_cnt;

    fifo_wr_arbiter_if bus();

    fifo_wr_arbiter #(.BURST_MAX(BM)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .arb_if (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] obs();
        return {bus.gnt0, bus.gnt1, bus.mux_sel, bus.fifo_wr_en};
    endfunction

    function automatic logic m_wr();
        return ((m_own == 0 && bus.req0) || (m_own == 1 && bus.req1)) && !bus.fifo_full;
    endfunction

    function automatic logic [3:0] m_exp();
        return {m_own == 0, m_own == 1, m_own == 0, m_wr()};
    endfunction

    function automatic int dut_cnt();
        return int'(dut.u_cnt.r_cnt);
    endfunction

    task automatic m_reset();
        m_own  = -1;
        m_last = 1;
        m_cnt  = 0;
    endtask

    task automatic m_clock();
        logic r0, r1, w, mine, other;
        int   nxt;
        r0  = bus.req0;
        r1  = bus.req1;
        w   = m_wr();
        nxt = m_own;
        if (m_own < 0) begin
            if (r0 && r1)  nxt = 1 - m_last;
            else if (r0)   nxt = 0;
            else if (r1)   nxt = 1;
        end else begin
            mine  = (m_own == 0) ? r0 : r1;
            other = (m_own == 0) ? r1 : r0;
            if (!mine)                                       nxt = other ? 1 - m_own : -1;
            else if (other && (m_cnt + int'(w) >= BM))       nxt = 1 - m_own;
        end
        if (nxt != m_own)         m_cnt = 0;
        else if (w && m_cnt < BM) m_cnt = m_cnt + 1;
        if (nxt >= 0) m_last = nxt;
        m_own = nxt;
    endtask

    task automatic drive(input logic r0, input logic r1, input logic full);
        bus.req0      = r0;
        bus.req1      = r1;
        bus.fifo_full = full;
    endtask

    task automatic tick();
        @(posedge clk);
        m_clock();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0);
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 1, 0);
        #2;
        total++;
        if (obs() !== 4'b0000 || dut_cnt() !== 0) begin
            bad++; $display("FAIL reset_vals: got %b cnt=%0d want 0000 cnt=0", obs(), dut_cnt());
        end
        @(posedge clk);
        #1;
        total++;
        if (obs() !== 4'b0000) begin
            bad++; $display("FAIL reset_held: got %b want 0000", obs());
        end
        drive(0, 0, 0);
        m_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_lone_req0();
        do_reset();
        drive(1, 0, 0);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            total++;
            if (obs() !== m_exp()) begin
                bad++; $display("FAIL lone cyc%0d: got %b want %b", i, obs(), m_exp());
            end
            tick();
        end
        total++;
        if (dut_cnt() !== BM) begin
            bad++; $display("FAIL lone_sat: got cnt=%0d want %0d", dut_cnt(), BM);
        end
    endtask

    task automatic test_both_pattern();
        int k;
        int own;
        k = 0;
        do_reset();
        drive(1, 1, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (obs() !== m_exp()) begin
                bad++; $display("FAIL both cyc%0d: got %b want %b", i, obs(), m_exp());
            end
            if (i > 0) begin
                total++;
                if (bus.fifo_wr_en !== 1'b1) begin
                    bad++; $display("FAIL both_gap cyc%0d: got wr_en=%b want 1", i, bus.fifo_wr_en);
                end
            end
            if (bus.fifo_wr_en === 1'b1) begin
                own = bus.mux_sel ? 0 : 1;
                total++;
                if (own !== (k / BM) % 2) begin
                    bad++; $display("FAIL both_order write%0d: got req%0d want req%0d", k, own, (k / BM) % 2);
                end
                k++;
            end
            tick();
        end
        total++;
        if (k !== 19) begin
            bad++; $display("FAIL both_count: got %0d want 19", k);
        end
    endtask

    task automatic test_drop();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(i < 3, 1, 0);
            @(negedge clk);
            total++;
            if (obs() !== m_exp()) begin
                bad++; $display("FAIL drop cyc%0d: got %b want %b", i, obs(), m_exp());
            end
            if (i == 4) begin
                total++;
                if ({bus.gnt1, bus.fifo_wr_en} !== 2'b11) begin
                    bad++; $display("FAIL drop_first1: got gnt1/wr=%b want 11", {bus.gnt1, bus.fifo_wr_en});
                end
            end
            tick();
        end
    endtask

    task automatic test_full_mid();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(1, 1, i >= 3 && i < 6);
            @(negedge clk);
            total++;
            if (obs() !== m_exp() || dut_cnt() !== m_cnt) begin
                bad++; $display("FAIL full_mid cyc%0d: got %b cnt=%0d want %b cnt=%0d",
                                i, obs(), dut_cnt(), m_exp(), m_cnt);
            end
            tick();
        end
    endtask

    task automatic test_full_stuck();
        int  writes;
        logic saw_g1;
        writes = 0;
        saw_g1 = 1'b0;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            if (i < 7) drive(1, 0, 0);
            else       drive(1, 1, 1);
            @(negedge clk);
            total++;
            if (obs() !== m_exp()) begin
                bad++; $display("FAIL stuck cyc%0d: got %b want %b", i, obs(), m_exp());
            end
            if (i >= 7) begin
                if (bus.fifo_wr_en === 1'b1) writes++;
                if (bus.gnt1 === 1'b1) saw_g1 = 1'b1;
            end
            tick();
        end
        total++;
        if (writes !== 0 || saw_g1 !== 1'b1) begin
            bad++; $display("FAIL stuck_summary: got writes=%0d g1=%b want writes=0 g1=1", writes, saw_g1);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (obs() !== m_exp()) begin
                bad++; $display("FAIL arst_pre cyc%0d: got %b want %b", i, obs(), m_exp());
            end
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs() !== 4'b0000 || dut_cnt() !== 0) begin
            bad++; $display("FAIL arst_async: got %b cnt=%0d want 0000 cnt=0", obs(), dut_cnt());
        end
        @(posedge clk);
        m_reset();
        #1;
        rst_n = 1'b1;
        drive(1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (obs() !== m_exp()) begin
                bad++; $display("FAIL arst_post cyc%0d: got %b want %b", i, obs(), m_exp());
            end
            if (i == 1) begin
                total++;
                if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
                    bad++; $display("FAIL arst_first: got gnt=%b want 10", {bus.gnt0, bus.gnt1});
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        int   p0, p1, own;
        logic w;
        p0 = 0;
        p1 = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(p0 > 0, p1 > 0, $urandom_range(0, 3) == 0);
            @(negedge clk);
            total++;
            if (obs() !== m_exp() || dut_cnt() !== m_cnt) begin
                bad++; $display("FAIL rand cyc%0d: got %b cnt=%0d want %b cnt=%0d",
                                i, obs(), dut_cnt(), m_exp(), m_cnt);
            end
            @(posedge clk);
            w   = m_wr();
            own = m_own;
            m_clock();
            #1;
            if (w) begin
                if (own == 0) p0--;
                else          p1--;
            end
            if ($urandom_range(0, 3) == 0) p0 += $urandom_range(1, 6);
            if ($urandom_range(0, 3) == 0) p1 += $urandom_range(1, 6);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_reset();
        drive(0, 0, 0);
        rst_n = 1'b0;
        test_reset();
        test_lone_req0();
        test_both_pattern();
        test_drop();
        test_full_mid();
        test_full_stuck();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
